// File: rtl/mem_sdp_ctrl.sv
// Simple-dual-port scratch memory with byte enables, write-first bypass and a clear engine.
// Latency: read data and rd_valid one cycle after an accepted read; addr_err one cycle after.
// Backpressure: none on the ports; while busy (clearing) every request is silently ignored.
module mem_sdp_ctrl #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW/8-1:0] wr_be,
  input  logic [DW-1:0]   wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  input  logic            clr_req,
  output logic            busy,
  output logic            addr_err
);

  localparam int NB = DW / 8;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          addr_err_q, addr_err_d;

  // Array is deliberately not reset; the clear engine zeroes it word by word.
  logic [DW-1:0] mem [DEPTH];

  logic          run;
  logic          wr_in_rng, rd_in_rng, wr_ok, rd_ok;
  logic [DW-1:0] wr_old, wr_merged, rd_word;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  // Request qualification, byte merge, write-first read mux and next-state logic.
  always_comb begin
    run       = (state_q == ST_RUN);
    wr_in_rng = ({1'b0, wr_addr} < DEPTH_W);
    rd_in_rng = ({1'b0, rd_addr} < DEPTH_W);
    wr_ok     = run && wr_en && wr_in_rng;
    rd_ok     = run && rd_en;

    // Merge against the stored word so unselected bytes survive.
    wr_old    = wr_in_rng ? mem[wr_addr] : '0;
    wr_merged = wr_old;
    for (int k = 0; k < NB; k++) begin
      if (wr_be[k]) wr_merged[8*k +: 8] = wr_data[8*k +: 8];
    end

    // Same-address collision returns the merged word (write-first).
    rd_word = '0;
    if (rd_in_rng) begin
      rd_word = (wr_ok && (wr_addr == rd_addr)) ? wr_merged : mem[rd_addr];
    end

    mem_we    = run ? wr_ok : 1'b1;
    mem_waddr = run ? wr_addr : ptr_q;
    mem_wdata = run ? wr_merged : '0;

    state_d    = state_q;
    ptr_d      = ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;

    if (run) begin
      if (rd_ok) begin
        rd_data_d  = rd_word;
        rd_valid_d = 1'b1;
      end
      // One pulse even when both ports are out of range together.
      addr_err_d = (wr_en && !wr_in_rng) || (rd_en && !rd_in_rng);
      if (clr_req) begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    end else begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LAST) begin
        state_d = ST_RUN;
        ptr_d   = '0;
      end
    end
  end

  // Control and output registers; reset restarts the clear sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Single write port shared by user writes and the clear engine.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_mem_sdp_ctrl.sv
// Directed bench for mem_sdp_ctrl: a DW=8/DEPTH=16 instance and a DW=32/DEPTH=11 instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Each step has a hand-computed expectation checked with an immediate assertion.
module tb_mem_sdp_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DW=8, DEPTH=16
  logic       wr_en_a = 0, rd_en_a = 0, clr_a = 0;
  logic [3:0] wr_addr_a = 0, rd_addr_a = 0;
  logic [0:0] wr_be_a = 0;
  logic [7:0] wr_data_a = 0, rd_data_a;
  logic       rd_valid_a, busy_a, addr_err_a;

  // Instance B: DW=32, DEPTH=11
  logic        wr_en_b = 0, rd_en_b = 0, clr_b = 0;
  logic [3:0]  wr_addr_b = 0, rd_addr_b = 0;
  logic [3:0]  wr_be_b = 0;
  logic [31:0] wr_data_b = 0, rd_data_b;
  logic        rd_valid_b, busy_b, addr_err_b;

  mem_sdp_ctrl #(.DW(8), .DEPTH(16), .AW(4)) u_a (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_be(wr_be_a), .wr_data(wr_data_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .clr_req(clr_a), .busy(busy_a), .addr_err(addr_err_a)
  );

  mem_sdp_ctrl #(.DW(32), .DEPTH(11), .AW(4)) u_b (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_be(wr_be_b), .wr_data(wr_data_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .clr_req(clr_b), .busy(busy_b), .addr_err(addr_err_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values while reset is held.
    #1;
    check("rst_busy_a", busy_a, 1);
    check("rst_rd_valid_a", rd_valid_a, 0);
    check("rst_rd_data_a", rd_data_a, 0);
    check("rst_addr_err_a", addr_err_a, 0);
    check("rst_busy_b", busy_b, 1);
    tick();

    // 1) Clear after reset: busy for exactly 16 cycles even with rd_en held.
    rd_en_a = 1; rd_addr_a = 0;
    reset_n = 1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("init_busy_a_%0d", i), busy_a, 1);
      check($sformatf("init_rdv_a_%0d", i), rd_valid_a, 0);
      tick();
    end
    check("init_busy_done_a", busy_a, 0);
    check("init_busy_done_b", busy_b, 0);
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a);
      tick();
      check($sformatf("init_rd_a_%0d", a), rd_data_a, 8'h00);
      check($sformatf("init_rdv_a_%0d", a), rd_valid_a, 1);
    end
    rd_en_a = 0;
    tick();
    check("idle_rdv_a", rd_valid_a, 0);

    // 3) Same-cycle write and read of addr 7: write-first.
    wr_en_a = 1; wr_addr_a = 7; wr_be_a = 1; wr_data_a = 8'h5A;
    rd_en_a = 1; rd_addr_a = 7;
    tick();
    check("bypass_data", rd_data_a, 8'h5A);
    check("bypass_vld", rd_valid_a, 1);
    check("bypass_err", addr_err_a, 0);
    wr_en_a = 0; rd_en_a = 0;
    tick();
    check("hold_vld", rd_valid_a, 0);
    check("hold_data", rd_data_a, 8'h5A);

    // 2) Byte-enable merge on the 32-bit instance.
    wr_en_b = 1; wr_addr_b = 3; wr_be_b = 4'b1111; wr_data_b = 32'hAABBCCDD;
    tick();
    wr_be_b = 4'b0101; wr_data_b = 32'h11223344;
    tick();
    wr_en_b = 0; rd_en_b = 1; rd_addr_b = 3;
    tick();
    check("be_merge", rd_data_b, 32'hAA22CC44);
    check("be_merge_vld", rd_valid_b, 1);
    // wr_be=0 is a no-op.
    rd_en_b = 0; wr_en_b = 1; wr_be_b = 4'b0000; wr_data_b = 32'h0;
    tick();
    check("be_merge_vld_off", rd_valid_b, 0);
    wr_en_b = 0; rd_en_b = 1;
    tick();
    check("be_zero_noop", rd_data_b, 32'hAA22CC44);
    rd_en_b = 0;

    // 4) Out-of-range write on DEPTH=11.
    wr_en_b = 1; wr_addr_b = 12; wr_be_b = 4'b1111; wr_data_b = 32'h000000FF;
    tick();
    check("oor_wr_err", addr_err_b, 1);
    wr_en_b = 0;
    tick();
    check("oor_wr_err_pulse", addr_err_b, 0);
    rd_en_b = 1;
    for (int a = 0; a < 11; a++) begin
      rd_addr_b = 4'(a);
      tick();
      check($sformatf("oor_scan_%0d", a), rd_data_b, (a == 3) ? 32'hAA22CC44 : 32'h0);
    end
    // Last read was addr 10 (zero); read addr 3 again so the out-of-range read visibly zeroes.
    rd_addr_b = 3;
    tick();
    check("pre_oor_rd", rd_data_b, 32'hAA22CC44);
    rd_addr_b = 11;
    tick();
    check("oor_rd_data", rd_data_b, 32'h0);
    check("oor_rd_vld", rd_valid_b, 1);
    check("oor_rd_err", addr_err_b, 1);
    // Both ports bad together: single pulse.
    wr_en_b = 1; wr_addr_b = 13; rd_addr_b = 14;
    tick();
    check("oor_both_err", addr_err_b, 1);
    wr_en_b = 0; rd_en_b = 0;
    tick();
    check("oor_both_pulse", addr_err_b, 0);
    check("oor_both_vld_off", rd_valid_b, 0);

    // 5) Fill with 0x33, then clear together with a write of 0x44 to addr 0.
    wr_en_a = 1; wr_be_a = 1; wr_data_a = 8'h33;
    for (int a = 0; a < 16; a++) begin
      wr_addr_a = 4'(a);
      tick();
    end
    wr_addr_a = 0; wr_data_a = 8'h44;
    rd_en_a = 1; rd_addr_a = 5;
    clr_a = 1;
    tick();
    clr_a = 0; wr_en_a = 0;
    check("clr_same_cycle_rd", rd_data_a, 8'h33);
    check("clr_same_cycle_vld", rd_valid_a, 1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("clr_busy_%0d", i), busy_a, 1);
      tick();
      check($sformatf("clr_rdv_%0d", i), rd_valid_a, 0);
    end
    check("clr_busy_done", busy_a, 0);
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a);
      tick();
      check($sformatf("clr_rd_%0d", a), rd_data_a, 8'h00);
    end
    rd_en_a = 0;

    // Make rd_data nonzero so the reset value is observable.
    wr_en_a = 1; wr_addr_a = 2; wr_data_a = 8'hC3;
    tick();
    wr_en_a = 0; rd_en_a = 1; rd_addr_a = 2;
    tick();
    rd_en_a = 0;
    check("pre_rst_data", rd_data_a, 8'hC3);

    // 6) Reset at clear cycle 5 restarts the clear.
    clr_a = 1;
    tick();
    clr_a = 0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_clr_busy", busy_a, 1);
    reset_n = 0;
    #1;
    check("mid_rst_busy", busy_a, 1);
    check("mid_rst_data", rd_data_a, 0);
    check("mid_rst_vld", rd_valid_a, 0);
    tick();
    reset_n = 1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rst_clr_busy_%0d", i), busy_a, 1);
      tick();
    end
    check("rst_clr_done", busy_a, 0);
    rd_en_a = 1; rd_addr_a = 2;
    tick();
    check("rst_clr_rd", rd_data_a, 8'h00);
    check("rst_clr_vld", rd_valid_a, 1);
    rd_en_a = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
